// File: rtl/prefix_pkg.sv
// Shared constants and FSM state type for the sequential
// Kogge-Stone prefix adder.
package prefix_pkg;
  localparam int WIDTH  = 32;
  localparam int LEVELS = 5;

  typedef enum logic [1:0] {
    IDLE,
    LEVEL,
    DONE
  } state_t;
endpackage

// File: rtl/prefix_add_seq_if.sv
// Operand/result handshake bundle for prefix_add_seq.
// master drives operands and takes results; slave is the adder.
interface prefix_add_seq_if;
  import prefix_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/gp_block.sv
// Kogge-Stone combine cell: merges a high (g,p) span
// with the adjacent lower span.
module GP_block (
  input  logic i_g_hi,
  input  logic i_p_hi,
  input  logic i_g_lo,
  input  logic i_p_lo,
  output logic o_g,
  output logic o_p
);
  assign o_g = i_g_hi | (i_p_hi & i_g_lo);
  assign o_p = i_p_hi & i_p_lo;
endmodule

// File: rtl/prefix_level.sv
// One Kogge-Stone row with run-time span i_d;
// bits below i_d pass straight through.
module prefix_level
  import prefix_pkg::*;
(
  input  logic [WIDTH-1:0] i_g,
  input  logic [WIDTH-1:0] i_p,
  input  logic [LEVELS:0]  i_d,
  output logic [WIDTH-1:0] o_g,
  output logic [WIDTH-1:0] o_p
);
  logic [WIDTH-1:0] w_g_lo;
  logic [WIDTH-1:0] w_p_lo;
  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;

  // bit i of the shifted vectors is the partner bit i-d
  assign w_g_lo = i_g << i_d;
  assign w_p_lo = i_p << i_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    GP_block u_gp (
      .i_g_hi (i_g[i]),
      .i_p_hi (i_p[i]),
      .i_g_lo (w_g_lo[i]),
      .i_p_lo (w_p_lo[i]),
      .o_g    (w_g[i]),
      .o_p    (w_p[i])
    );

    assign o_g[i] = (i_d <= (LEVELS+1)'(i)) ? w_g[i] : i_g[i];
    assign o_p[i] = (i_d <= (LEVELS+1)'(i)) ? w_p[i] : i_p[i];
  end
endmodule

// File: rtl/prefix_add_seq.sv
// Sequential 32-bit adder: one shared prefix row iterated
// over five LEVEL cycles, result held in DONE until taken.
module prefix_add_seq #(
  parameter int WIDTH  = 32,
  parameter int LEVELS = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  prefix_add_seq_if.slave   bus,
  output logic              busy,
  output logic [15:0]       op_count
);
  import prefix_pkg::*;

  state_t           r_state;
  logic [2:0]       r_lvl;
  logic [WIDTH-1:0] r_g;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_h;
  logic             r_cin;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic [15:0]      r_op_count;

  logic [WIDTH-1:0] w_g0;
  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [LEVELS:0]  w_d;

  // carry-in is folded into bit 0's generate at load
  always_comb begin
    w_g0    = bus.a & bus.b;
    w_g0[0] = (bus.a[0] & bus.b[0]) |
              ((bus.a[0] ^ bus.b[0]) & bus.cin);
  end

  assign w_d = (LEVELS+1)'(1) << r_lvl;

  prefix_level u_level (
    .i_g (r_g),
    .i_p (r_p),
    .i_d (w_d),
    .o_g (w_g),
    .o_p (w_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_lvl      <= '0;
      r_g        <= '0;
      r_p        <= '0;
      r_h        <= '0;
      r_cin      <= 1'b0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_op_count <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_h     <= bus.a ^ bus.b;
            r_p     <= bus.a ^ bus.b;
            r_g     <= w_g0;
            r_cin   <= bus.cin;
            r_lvl   <= '0;
            r_state <= LEVEL;
          end
        end
        LEVEL: begin
          r_g   <= w_g;
          r_p   <= w_p;
          r_lvl <= r_lvl + 3'd1;
          if (r_lvl == 3'(LEVELS-1)) begin
            r_sum   <= r_h ^ {w_g[WIDTH-2:0], r_cin};
            r_cout  <= w_g[WIDTH-1];
            r_state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_op_count <= r_op_count + 16'd1;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign busy          = (r_state != IDLE);
  assign op_count      = r_op_count;
endmodule

// File: tb/tb_prefix_add_seq.sv
// Directed bench for prefix_add_seq: arithmetic model,
// latency, stall hold, mid-op reset and counter wrap.
module tb_prefix_add_seq;
  logic        clk;
  logic        rst_n;
  logic        busy;
  logic [15:0] op_count;

  prefix_add_seq_if bus ();

  prefix_add_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [32:0] exp_res;
  logic [15:0] exp_cnt;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // whenever a result is presented it must equal a+b+cin
  always @(negedge clk) begin
    if (rst_n && bus.out_valid)
      chk("model_sum", {31'd0, bus.cout, bus.sum}, {31'd0, exp_res});
  end

  task automatic run_op(input logic [31:0] a,
                        input logic [31:0] b,
                        input logic        ci,
                        input logic [32:0] lit,
                        input int          stall,
                        input string       nm);
    int n;
    logic [32:0] held;
    @(negedge clk);
    exp_res      = {1'b0, a} + {1'b0, b} + {32'd0, ci};
    bus.a        = a;
    bus.b        = b;
    bus.cin      = ci;
    bus.in_valid = 1'b1;
    chk({nm, "_in_ready"}, {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    #1;
    // operands change while busy and must be ignored
    bus.a   = ~a;
    bus.b   = a ^ 32'h5A5A_5A5A;
    bus.cin = ~ci;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.out_valid || n >= 10) break;
      chk({nm, "_busy"}, {62'd0, busy, bus.in_ready}, 64'd2);
      @(posedge clk);
      n++;
    end
    bus.in_valid = 1'b0;
    chk({nm, "_latency"}, 64'(n), 64'd5);
    chk({nm, "_lit"}, {31'd0, bus.cout, bus.sum}, {31'd0, lit});
    held = {bus.cout, bus.sum};
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      @(negedge clk);
      chk({nm, "_hold"}, {31'd0, bus.cout, bus.sum}, {31'd0, held});
      chk({nm, "_stall"}, {47'd0, bus.in_ready, op_count},
          {47'd0, 1'b0, exp_cnt});
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    chk({nm, "_drain"},
        {46'd0, bus.in_ready, bus.out_valid, op_count},
        {46'd0, 1'b1, 1'b0, exp_cnt});
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
    exp_res       = '0;
    exp_cnt       = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctl", {60'd0, bus.in_ready, bus.out_valid, busy, 1'b0},
        {60'd0, 4'b1000});
    chk("reset_data", {15'd0, op_count, bus.cout, bus.sum}, 64'd0);
    rst_n = 1'b1;

    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33'h1_0000_0000, 0, "wrap");
    run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 33'h0_ACF1_3569, 0, "mix");
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 33'h1_0000_0001, 0, "msb");
    run_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, 33'h0_0001_0000, 3, "stall");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF, 0, "ones");
    run_op(32'h0000_0000, 32'h0000_0000, 1'b1, 33'h0_0000_0001, 1, "cin");

    // reset while the row is at lvl=2
    @(negedge clk);
    exp_res      = 33'h0_0000_0003;
    bus.a        = 32'h1;
    bus.b        = 32'h2;
    bus.cin      = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_cnt = '0;
    chk("midrst_ctl", {60'd0, bus.in_ready, bus.out_valid, busy, 1'b0},
        {60'd0, 4'b1000});
    chk("midrst_data", {15'd0, op_count, bus.cout, bus.sum}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("midrst_noresult", {62'd0, bus.out_valid, busy}, 64'd0);
    end
    run_op(32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 33'h0_DFD1_0456, 0, "postrst");

    // preload the counter just below wrap
    @(negedge clk);
    force dut.r_op_count = 16'hFFFF;
    #1 release dut.r_op_count;
    exp_cnt = 16'hFFFF;
    @(negedge clk);
    chk("preload", {48'd0, op_count}, 64'hFFFF);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 33'h0_8000_0000, 0, "cntwrap");
    chk("cnt_zero", {48'd0, op_count}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
